instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: a PC register that walks program memory and a
// 2-entry {instruction, PC} queue toward the decoder. Handles backpressure,
// redirects (branch/jump flushes), and halts on an out-of-range or
// misaligned fetch address.
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] PC_RESET     = 32'h00400000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] FetchAddress,
  input  logic [DATA_WIDTH-1:0] MemInstruction,
  input  logic                  Redirect,
  input  logic [DATA_WIDTH-1:0] RedirectAddress,
  output logic                  InstrValid,
  input  logic                  InstrReady,
  output logic [DATA_WIDTH-1:0] InstrOut,
  output logic [DATA_WIDTH-1:0] InstrPC,
  output logic                  FetchError,
  output logic [31:0]           RetiredCount
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(MEMORY_DEPTH);

  state_t                state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] offset;
  logic                  pc_ok;
  logic [1:0]            count;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic                  deq;
  logic                  enq;

  logic [DATA_WIDTH-1:0] instr_q [2];
  logic [DATA_WIDTH-1:0] pc_q    [2];

  // Decide whether the current PC is fetchable and what moves this cycle.
  always_comb begin
    offset = pc - PC_RESET;
    pc_ok  = (pc[1:0] == 2'b00) && (pc >= PC_RESET) && ((offset >> 2) < DEPTH_W);
    deq    = InstrValid & InstrReady;
    enq    = (state == RUN) & ~Redirect & pc_ok & ((count < 2'd2) | deq);
  end

  assign FetchAddress = pc;
  assign InstrValid   = (count != 2'd0);
  assign InstrOut     = instr_q[rd_ptr];
  assign InstrPC      = pc_q[rd_ptr];
  assign FetchError   = (state == HALT);

  // Control state: PC, run/halt FSM, queue occupancy and pointers, retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= PC_RESET;
      state        <= RUN;
      count        <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      RetiredCount <= 32'd0;
    end else begin
      // A redirect flushes the queue, but a deq in the same cycle still retires.
      if (deq) RetiredCount <= RetiredCount + 32'd1;

      if (Redirect) begin
        pc     <= RedirectAddress;
        state  <= RUN;
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (state == RUN && !pc_ok) state <= HALT;
        if (enq) begin
          pc     <= pc + DATA_WIDTH'(4);
          wr_ptr <= ~wr_ptr;
        end
        if (deq) rd_ptr <= ~rd_ptr;
        case ({enq, deq})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // Queue payload storage, written at the tail on every fetch.
  // NOTE: payload registers carry no reset; count alone decides validity, so
  // stale contents are never observable and the data path stays reset-free.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_q[wr_ptr] <= MemInstruction;
      pc_q[wr_ptr]    <= pc;
    end
  end

endmodule
